// File: rtl/nrs_pkg.sv
// Shared constants and state encoding for the NB-IoT NRS Gold-sequence sequencer.
// Used by nrs_cinit_calc and nrs_gold_seq_ctrl.
package nrs_pkg;

    localparam int NC           = 1600;
    localparam int NRS_M_OFFSET = 109;
    localparam int LFSR_W       = 31;
    localparam int NCELL_ID_MAX = 503;
    localparam int CINIT_W      = 28;

    typedef logic [2:0] nrs_state_t;

    localparam nrs_state_t ST_IDLE = 3'd0;
    localparam nrs_state_t ST_CALC = 3'd1;
    localparam nrs_state_t ST_LOAD = 3'd2;
    localparam nrs_state_t ST_SKIP = 3'd3;
    localparam nrs_state_t ST_EMIT = 3'd4;
    localparam nrs_state_t ST_DONE = 3'd5;

endpackage

// File: rtl/nrs_cinit_calc.sv
// Combinational NRS c_init: 2^10*(7*(ns+1)+l+1)*(2*ncell_id+1) + 2*ncell_id + 1.
// Evaluated at 28 bits (enough for in-range inputs) and zero-extended to the LFSR width.
module nrs_cinit_calc
    import nrs_pkg::*;
(
    input  logic [4:0]        ns_i,
    input  logic [2:0]        l_i,
    input  logic [8:0]        ncell_id_i,
    output logic [LFSR_W-1:0] c_init_o
);

    logic [7:0]         symTerm;
    logic [9:0]         cellTerm;
    logic [CINIT_W-1:0] product;

    always_comb begin
        symTerm  = 8'd7 * (8'(ns_i) + 8'd1) + 8'(l_i) + 8'd1;
        cellTerm = {ncell_id_i, 1'b1};
        product  = CINIT_W'(symTerm) * CINIT_W'(cellTerm);
        // product is below 2^18, so the 2^10 scaling cannot overflow 28 bits
        c_init_o = LFSR_W'({product[CINIT_W-11:0], 10'd0} + CINIT_W'(cellTerm));
    end

endmodule

// File: rtl/nrs_gold_seq_ctrl.sv
// Sequencer for the NRS Gold-sequence generator: c_init, LFSR load, fast-forward, bit emission.
// Optional feature: define NRS_CTRL_ABORT_EN to add an abort input that returns any request to IDLE.
module nrs_gold_seq_ctrl
    import nrs_pkg::*;
#(
    parameter int SKIP_CNT = NC + 2 * NRS_M_OFFSET - 30,
    parameter int OUT_BITS = 4,
    parameter int CNT_W    = 11
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        ns,
    input  logic [2:0]        l,
    input  logic [8:0]        ncell_id,
    input  logic              x1_bit,
    input  logic              x2_bit,
`ifdef NRS_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              x1_en,
    output logic              x2_en,
    output logic              x1_init,
    output logic              x2_init,
    output logic              x1_out,
    output logic              x2_out,
    output logic [LFSR_W-1:0] x2_seed,
    output logic              c_bit,
    output logic              c_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_CNT > 0 ? SKIP_CNT - 1 : 0);
    localparam logic [CNT_W-1:0] EMIT_LAST = CNT_W'(OUT_BITS - 1);

    nrs_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [4:0]        ns_q, ns_d;
    logic [2:0]        l_q, l_d;
    logic [8:0]        cid_q, cid_d;
    logic              c_bit_q, c_bit_d;
    logic              c_valid_q, c_valid_d;
    logic              abortReq;
    logic [LFSR_W-1:0] cinit;

`ifdef NRS_CTRL_ABORT_EN
    assign abortReq = abort;
`else
    assign abortReq = 1'b0;
`endif

    nrs_cinit_calc u_cinit (
        .ns_i       (ns_q),
        .l_i        (l_q),
        .ncell_id_i (cid_q),
        .c_init_o   (cinit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seed_d    = seed_q;
        ns_d      = ns_q;
        l_d       = l_q;
        cid_d     = cid_q;
        c_bit_d   = c_bit_q;
        c_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abortReq) begin
                    ns_d    = ns;
                    l_d     = l;
                    cid_d   = ncell_id;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                seed_d  = cinit;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = (SKIP_CNT == 0) ? ST_EMIT : ST_SKIP;
            end
            ST_SKIP: begin
                if (cnt_q == SKIP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_EMIT: begin
                c_bit_d   = x1_bit ^ x2_bit;
                c_valid_d = 1'b1;
                if (cnt_q == EMIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // abort wins over any in-progress step; the seed keeps its last loaded value
        if (abortReq && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            seed_d    = seed_q;
            c_bit_d   = c_bit_q;
            c_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            seed_q    <= '0;
            ns_q      <= '0;
            l_q       <= '0;
            cid_q     <= '0;
            c_bit_q   <= 1'b0;
            c_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seed_q    <= seed_d;
            ns_q      <= ns_d;
            l_q       <= l_d;
            cid_q     <= cid_d;
            c_bit_q   <= c_bit_d;
            c_valid_q <= c_valid_d;
        end
    end

    assign x1_init = (state_q == ST_LOAD);
    assign x2_init = x1_init;
    assign x1_en   = (state_q == ST_SKIP) || (state_q == ST_EMIT);
    assign x2_en   = x1_en;
    assign x1_out  = (state_q == ST_EMIT);
    assign x2_out  = x1_out;
    assign x2_seed = seed_q;
    assign c_bit   = c_bit_q;
    assign c_valid = c_valid_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_nrs_gold_seq_ctrl.sv
// Randomized self-checking bench for nrs_gold_seq_ctrl with behavioural x1/x2 LFSRs
// and a sequence-level Gold reference; the abort scenario is built when NRS_CTRL_ABORT_EN is defined.
module tb_nrs_gold_seq_ctrl;

    localparam int SKIP_CNT = 1788;
    localparam int OUT_BITS = 4;
    localparam int BUDGET   = 2500;
    localparam int SEQ_LEN  = 1900;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  ns = '0;
    logic [2:0]  l = '0;
    logic [8:0]  ncell_id = '0;
    logic        x1_bit, x2_bit;
    logic        x1_en, x2_en, x1_init, x2_init, x1_out, x2_out;
    logic [30:0] x2_seed;
    logic        c_bit, c_valid, busy, done;
`ifdef NRS_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    logic [30:0] x1Reg = '0;
    logic [30:0] x2Reg = '0;

    always #5 clk = ~clk;

    nrs_gold_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ns       (ns),
        .l        (l),
        .ncell_id (ncell_id),
        .x1_bit   (x1_bit),
        .x2_bit   (x2_bit),
`ifdef NRS_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .x1_en    (x1_en),
        .x2_en    (x2_en),
        .x1_init  (x1_init),
        .x2_init  (x2_init),
        .x1_out   (x1_out),
        .x2_out   (x2_out),
        .x2_seed  (x2_seed),
        .c_bit    (c_bit),
        .c_valid  (c_valid),
        .busy     (busy),
        .done     (done)
    );

    // External LFSRs: bit i holds x(k+i), the output tap is the MSB
    always @(posedge clk) begin
        if (x1_init) x1Reg <= 31'd1;
        else if (x1_en) x1Reg <= {x1Reg[0] ^ x1Reg[3], x1Reg[30:1]};
        if (x2_init) x2Reg <= x2_seed;
        else if (x2_en) x2Reg <= {x2Reg[0] ^ x2Reg[1] ^ x2Reg[2] ^ x2Reg[3], x2Reg[30:1]};
    end

    assign x1_bit = x1_out ? x1Reg[30] : 1'b0;
    assign x2_bit = x2_out ? x2Reg[30] : 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [30:0] modelSeed(input int nsV, input int lV, input int cid);
        return 31'(1024 * (7 * (nsV + 1) + lV + 1) * (2 * cid + 1) + 2 * cid + 1);
    endfunction

    // Gold sequence from the 36.211 recurrences; bit m is c(2*109 + m)
    function automatic logic [3:0] modelBits(input logic [30:0] cinit);
        bit x1s [SEQ_LEN];
        bit x2s [SEQ_LEN];
        logic [3:0] bits = '0;
        for (int i = 0; i < 31; i++) begin
            x1s[i] = (i == 0);
            x2s[i] = cinit[i];
        end
        for (int n = 0; n + 31 < SEQ_LEN; n++) begin
            x1s[n + 31] = x1s[n + 3] ^ x1s[n];
            x2s[n + 31] = x2s[n + 3] ^ x2s[n + 2] ^ x2s[n + 1] ^ x2s[n];
        end
        for (int m = 0; m < OUT_BITS; m++)
            bits[m] = x1s[1600 + 2 * 109 + m] ^ x2s[1600 + 2 * 109 + m];
        return bits;
    endfunction

    task automatic checkQuiet(input string tag, input bit seedZero);
        checkOutput(tag, 64'({busy, done, c_valid, c_bit, x1_en, x2_en, x1_init, x2_init, x1_out, x2_out}), 64'd0);
        if (seedZero) checkOutput({tag, "_seed"}, 64'(x2_seed), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("proto_init_en", 64'(x1_init & x1_en), 64'd0);
            checkOutput("proto_out_en", 64'(x1_out & ~x1_en), 64'd0);
            checkOutput("proto_pair", 64'({x1_en, x1_init, x1_out}), 64'({x2_en, x2_init, x2_out}));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done
    task automatic applyStimulus(input int nsV, input int lV, input int cid,
                                 input int resetAt, input int abortAt, input bit noise);
        logic [30:0] expSeed = modelSeed(nsV, lV, cid);
        logic [3:0]  expBits = modelBits(modelSeed(nsV, lV, cid));
        logic [3:0]  gotBits = '0;
        int enOnly = 0, inits = 0, nValid = 0, firstValid = -1, doneAt = -1;
        bit busyOk = 1'b1;
        ns = 5'(nsV); l = 3'(lV); ncell_id = 9'(cid); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ns = 5'($urandom); l = 3'($urandom); ncell_id = 9'($urandom);
        for (int t = 1; t <= BUDGET; t++) begin
            if (t == resetAt) begin
                rst = 1'b0;
                #1;
                checkQuiet("reset_mid", 1'b1);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (t == 2) checkOutput("seed", 64'(x2_seed), 64'(expSeed));
            if (x1_init) inits++;
            if (x1_en && !x1_out && !x1_init) enOnly++;
            if (!busy) busyOk = 1'b0;
            if (c_valid) begin
                if (nValid < OUT_BITS) gotBits[nValid] = c_bit;
                if (firstValid < 0) firstValid = t;
                nValid++;
            end
            if (done) begin
                doneAt = t;
                break;
            end
`ifdef NRS_CTRL_ABORT_EN
            if (t == abortAt) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                checkOutput("abort_bits_seen", 64'(nValid), 64'd2);
                checkOutput("abort_seed_held", 64'(x2_seed), 64'(expSeed));
                for (int k = 0; k < 3; k++) begin
                    checkQuiet("abort_quiet", 1'b0);
                    @(negedge clk);
                end
                return;
            end
`endif
            start = noise && (t == 700 || t == SKIP_CNT + 4);
            if (start) ns = 5'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("init_cycles", 64'(inits), 64'd1);
        checkOutput("skip_cycles", 64'(enOnly), 64'(SKIP_CNT));
        checkOutput("valid_count", 64'(nValid), 64'(OUT_BITS));
        checkOutput("first_valid", 64'(firstValid), 64'(3 + SKIP_CNT + 1));
        checkOutput("done_at", 64'(doneAt), 64'(3 + SKIP_CNT + OUT_BITS));
        checkOutput("gold_bits", 64'(gotBits), 64'(expBits));
        checkOutput("busy_held", 64'(busyOk), 64'd1);
        @(negedge clk);
        checkOutput("idle_after", 64'({busy, done, c_valid}), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkQuiet("reset", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkQuiet("post_reset", 1'b1);

        applyStimulus(0, 5, 0, 0, 0, 1'b0);
        applyStimulus(19, 6, 503, 0, 0, 1'b0);
        applyStimulus(int'($urandom_range(19, 0)), int'($urandom_range(6, 0)),
                      int'($urandom_range(503, 0)), 0, 0, 1'b1);
        applyStimulus(int'($urandom_range(19, 0)), int'($urandom_range(6, 0)),
                      int'($urandom_range(503, 0)), 600, 0, 1'b0);
        applyStimulus(int'($urandom_range(19, 0)), int'($urandom_range(6, 0)),
                      int'($urandom_range(503, 0)), 0, 0, 1'b0);
`ifdef NRS_CTRL_ABORT_EN
        applyStimulus(int'($urandom_range(19, 0)), int'($urandom_range(6, 0)),
                      int'($urandom_range(503, 0)), 0, SKIP_CNT + 5, 1'b0);
`endif
        for (int i = 0; i < 3; i++)
            applyStimulus(int'($urandom_range(19, 0)), int'($urandom_range(6, 0)),
                          int'($urandom_range(503, 0)), 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
